// File: rtl/ppu_frame_tile_sequencer.sv
`timescale 1ns/1ps
// ppu_frame_tile_sequencer
//   Frame-level scheduler for the PPU tile load engine. For every visible
//   scanline it requests sprite evaluation, then walks the 8-pixel tile
//   columns (shifted left by the fine-X scroll, with one extra column when
//   the scroll is non-zero) and hands each tile to the load engine. After
//   the last row it raises vblank and waits for the next frame.
//
// Ports
//   clk, rst         clock; asynchronous active-low reset
//   frame_start      one-cycle pulse at the start of a frame
//   fine_x           horizontal fine scroll, latched at frame_start
//   ppu_ctrl1        bit7 = NMI enable
//   ppu_ctrl2        bit3 = background enable, bit4 = sprite enable
//   vblank_clr       CPU status read, clears vblank
//   load_start       one-cycle start pulse to the tile load engine
//   load_busy        tile load engine busy
//   curr_row         screen row of the current tile
//   curr_col         screen column of the current tile (two's complement)
//   eval_start       one-cycle pulse, begin sprite evaluation for curr_row
//   eval_done        sprite evaluation complete (pulse or level)
//   vblank           vblank status flag
//   nmi              NMI request level = vblank & ppu_ctrl1[7]
//   frame_overrun    one-cycle pulse, frame_start arrived while rendering
//
// Load engine handshake: load_start is a one-cycle request issued only while
// load_busy is low. The engine acknowledges by raising load_busy and drops it
// when the tile is finished. If load_busy does not rise within ACK_TIMEOUT
// cycles of the request the tile is treated as done. curr_row/curr_col are
// held from load_start until load_busy falls.
module ppu_frame_tile_sequencer #(
  parameter int VISIBLE_ROWS  = 240,
  parameter int TILES_PER_ROW = 32,
  parameter int ACK_TIMEOUT   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic [2:0] fine_x,
  input  logic [7:0] ppu_ctrl1,
  input  logic [7:0] ppu_ctrl2,
  input  logic       vblank_clr,
  output logic       load_start,
  input  logic       load_busy,
  output logic [8:0] curr_row,
  output logic [8:0] curr_col,
  output logic       eval_start,
  input  logic       eval_done,
  output logic       vblank,
  output logic       nmi,
  output logic       frame_overrun
);

  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int TILE_W = $clog2(TILES_PER_ROW + 2);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ROW_EVAL   = 4'd1,
    EVAL_WAIT  = 4'd2,
    TILE_START = 4'd3,
    TILE_ACK   = 4'd4,
    TILE_WAIT  = 4'd5,
    TILE_NEXT  = 4'd6,
    NEXT_ROW   = 4'd7,
    VBLANK     = 4'd8
  } state_t;

  // Current sequencer state; kept as a named register so checkers can bind to it.
  state_t             state;
  logic [2:0]         fine_x_q;
  logic               render_en_q;
  logic [ACK_W-1:0]   ack_cnt;
  logic [TILE_W-1:0]  tile_cnt;
  logic [8:0]         col_init;
  logic [TILE_W-1:0]  ncols;
  logic               frame_idle;

  // First column sits fine_x pixels left of the screen edge (wraps negative).
  assign col_init   = 9'd0 - {6'b0, fine_x_q};
  assign ncols      = TILE_W'(TILES_PER_ROW) + TILE_W'(fine_x_q != 3'd0);
  assign frame_idle = (state == IDLE) || (state == VBLANK);
  assign nmi        = vblank & ppu_ctrl1[7];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      load_start    <= 1'b0;
      eval_start    <= 1'b0;
      frame_overrun <= 1'b0;
      curr_row      <= 9'd0;
      curr_col      <= 9'd0;
      vblank        <= 1'b0;
      ack_cnt       <= '0;
      tile_cnt      <= '0;
      fine_x_q      <= 3'd0;
      render_en_q   <= 1'b0;
    end else begin
      load_start    <= 1'b0;
      eval_start    <= 1'b0;
      frame_overrun <= 1'b0;

      // Clear first so the set on VBLANK entry below takes priority.
      if (vblank_clr) vblank <= 1'b0;

      if (frame_start && !frame_idle) frame_overrun <= 1'b1;

      case (state)
        IDLE, VBLANK: begin
          if (frame_start) begin
            fine_x_q    <= fine_x;
            render_en_q <= ppu_ctrl2[3] | ppu_ctrl2[4];
            vblank      <= 1'b0;
            curr_row    <= 9'd0;
            state       <= ROW_EVAL;
          end
        end

        ROW_EVAL: begin
          curr_col <= col_init;
          tile_cnt <= '0;
          if (render_en_q) begin
            eval_start <= 1'b1;
            state      <= EVAL_WAIT;
          end else begin
            state <= NEXT_ROW;
          end
        end

        EVAL_WAIT: begin
          // eval_start is still high in the first cycle here; a done seen in
          // that cycle belongs to an earlier request and is ignored.
          if (eval_done && !eval_start) state <= TILE_START;
        end

        TILE_START: begin
          if (!load_busy) begin
            load_start <= 1'b1;
            ack_cnt    <= '0;
            state      <= TILE_ACK;
          end
        end

        TILE_ACK: begin
          if (load_busy) begin
            state <= TILE_WAIT;
          end else begin
            ack_cnt <= ack_cnt + ACK_W'(1);
            if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) state <= TILE_NEXT;
          end
        end

        TILE_WAIT: begin
          if (!load_busy) state <= TILE_NEXT;
        end

        TILE_NEXT: begin
          curr_col <= curr_col + 9'd8;
          tile_cnt <= tile_cnt + TILE_W'(1);
          if (tile_cnt == ncols - TILE_W'(1)) state <= NEXT_ROW;
          else                                state <= TILE_START;
        end

        NEXT_ROW: begin
          if (curr_row == 9'(VISIBLE_ROWS - 1)) begin
            vblank <= 1'b1;
            state  <= VBLANK;
          end else begin
            curr_row <= curr_row + 9'd1;
            state    <= ROW_EVAL;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_frame_tile_sequencer.sv
`timescale 1ns/1ps
// Bench for ppu_frame_tile_sequencer: clock/reset, load engine and sprite
// evaluation responders, driver tasks, a scoreboard monitor popping expected
// tile positions / eval rows, and a final report.
module tb_ppu_frame_tile_sequencer;

  logic       clk;
  logic       rst;
  logic       frame_start;
  logic [2:0] fine_x;
  logic [7:0] ppu_ctrl1;
  logic [7:0] ppu_ctrl2;
  logic       vblank_clr;
  logic       load_start;
  logic       load_busy;
  logic [8:0] curr_row;
  logic [8:0] curr_col;
  logic       eval_start;
  logic       eval_done;
  logic       vblank;
  logic       nmi;
  logic       frame_overrun;

  int total;
  int bad;
  int ld_cnt;
  int ev_cnt;

  logic [17:0] exp_q[$];
  logic [8:0]  eval_q[$];
  logic [17:0] last_tile;

  int   busy_len;
  logic engine_on;
  logic eval_level;
  int   eval_lat;

  ppu_frame_tile_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .fine_x        (fine_x),
    .ppu_ctrl1     (ppu_ctrl1),
    .ppu_ctrl2     (ppu_ctrl2),
    .vblank_clr    (vblank_clr),
    .load_start    (load_start),
    .load_busy     (load_busy),
    .curr_row      (curr_row),
    .curr_col      (curr_col),
    .eval_start    (eval_start),
    .eval_done     (eval_done),
    .vblank        (vblank),
    .nmi           (nmi),
    .frame_overrun (frame_overrun)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- comparison ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- responders ----------------
  // Load engine: raises busy the cycle after seeing load_start, for busy_len cycles.
  initial begin : engine
    int cnt;
    cnt = 0;
    load_busy = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        load_busy = 1'b0;
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) load_busy = 1'b0;
      end else if (load_start && engine_on) begin
        load_busy = 1'b1;
        cnt = busy_len;
      end
    end
  end

  // Sprite evaluator: pulses eval_done eval_lat cycles after eval_start,
  // or holds it high permanently when eval_level is set.
  initial begin : evaluator
    int ecnt;
    ecnt = 0;
    eval_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        eval_done = 1'b0;
        ecnt = 0;
      end else if (eval_level) begin
        eval_done = 1'b1;
      end else if (ecnt > 0) begin
        ecnt--;
        if (ecnt == 0) eval_done = 1'b1;
      end else begin
        eval_done = 1'b0;
        if (eval_start) ecnt = eval_lat;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        if (load_start) begin
          ld_cnt++;
          check("busy_at_load_start", 32'(load_busy), 32'd0);
          last_tile = {curr_row, curr_col};
          if (exp_q.size() == 0) check("unexpected_load_start", 32'(load_start), 32'd0);
          else                   check("tile_row_col", 32'({curr_row, curr_col}), 32'(exp_q.pop_front()));
        end else if (load_busy) begin
          check("tile_stable_while_busy", 32'({curr_row, curr_col}), 32'(last_tile));
        end
        if (eval_start) begin
          ev_cnt++;
          if (eval_q.size() == 0) check("unexpected_eval_start", 32'(eval_start), 32'd0);
          else                    check("eval_row", 32'(curr_row), 32'(eval_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input logic [2:0] fx, input int nrows);
    logic [8:0] col;
    int ncols;
    ncols = (fx != 3'd0) ? 33 : 32;
    for (int r = 0; r < nrows; r++) begin
      eval_q.push_back(9'(r));
      col = 9'd0 - {6'd0, fx};
      for (int t = 0; t < ncols; t++) begin
        exp_q.push_back({9'(r), col});
        col = col + 9'd8;
      end
    end
  endtask

  // Returns one negedge after the pulse was driven.
  task automatic pulse_frame(input logic [2:0] fx);
    @(negedge clk);
    fine_x = fx;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic count_until_load(output int n, input int limit);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!load_start && n < limit);
    if (!load_start) check("load_start_timeout", 32'(load_start), 32'd1);
  endtask

  task automatic wait_row_busy(input logic [8:0] row, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(curr_row == row && load_busy) && n < limit);
    if (!(curr_row == row && load_busy)) check("row_busy_timeout", 32'(curr_row), 32'(row));
  endtask

  task automatic wait_q_empty(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("queue_drain", 32'(exp_q.size()), 32'd0);
  endtask

  // n counts negedges since the frame_start pulse was driven (already 1 on entry).
  task automatic wait_vblank(inout int n, input int limit);
    while (!vblank && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!vblank) check("vblank_timeout", 32'(vblank), 32'd1);
  endtask

  // Called just after a negedge: asynchronous reset mid-cycle.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    check("reset_outputs_zero",
          32'({load_start, eval_start, frame_overrun, vblank, nmi, curr_row, curr_col}), 32'd0);
    exp_q.delete();
    eval_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int n;
    int ld_before;
    total = 0; bad = 0; ld_cnt = 0; ev_cnt = 0;
    last_tile = '0;
    rst = 1'b0;
    frame_start = 1'b0;
    fine_x = 3'd0;
    ppu_ctrl1 = 8'h80;
    ppu_ctrl2 = 8'h18;
    vblank_clr = 1'b0;
    busy_len = 10;
    engine_on = 1'b1;
    eval_level = 1'b0;
    eval_lat = 2;

    repeat (3) @(negedge clk);
    check("rst_load_start", 32'(load_start), 32'd0);
    check("rst_eval_start", 32'(eval_start), 32'd0);
    check("rst_frame_overrun", 32'(frame_overrun), 32'd0);
    check("rst_curr_row", 32'(curr_row), 32'd0);
    check("rst_curr_col", 32'(curr_col), 32'd0);
    check("rst_vblank", 32'(vblank), 32'd0);
    check("rst_nmi", 32'(nmi), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Full frame, fine_x = 0, engine busy 10 cycles on row 0 then 1 cycle.
    push_frame(3'd0, 240);
    pulse_frame(3'd0);
    @(negedge clk);
    check("eval_latency_2", 32'(eval_start), 32'd1);
    wait_row_busy(9'd1, 2000);
    busy_len = 1;
    n = 1;
    wait_vblank(n, 60000);
    check("frame0_load_count", 32'(ld_cnt), 32'd7680);
    check("frame0_eval_count", 32'(ev_cnt), 32'd240);
    check("frame0_tiles_left", 32'(exp_q.size()), 32'd0);
    check("frame0_evals_left", 32'(eval_q.size()), 32'd0);

    // Render disabled, vblank_clr held: vblank must still rise (set wins).
    ppu_ctrl2 = 8'h00;
    vblank_clr = 1'b1;
    pulse_frame(3'd0);
    check("no_overrun_from_vblank", 32'(frame_overrun), 32'd0);
    n = 1;
    wait_vblank(n, 1000);
    check("vblank_delay_disabled", 32'(n - 1), 32'd480);
    @(negedge clk);
    check("vblank_clr_after_set", 32'(vblank), 32'd0);
    vblank_clr = 1'b0;

    // Render disabled with overrun at ~row 100, then NMI behaviour.
    pulse_frame(3'd0);
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      n++;
    end
    frame_start = 1'b1;
    @(negedge clk);
    n++;
    frame_start = 1'b0;
    check("overrun_pulse", 32'(frame_overrun), 32'd1);
    @(negedge clk);
    n++;
    check("overrun_one_cycle", 32'(frame_overrun), 32'd0);
    wait_vblank(n, 1000);
    check("vblank_delay_after_overrun", 32'(n - 1), 32'd480);
    check("nmi_enabled", 32'(nmi), 32'd1);
    ppu_ctrl1 = 8'h00;
    #1;
    check("nmi_ctrl_off", 32'(nmi), 32'd0);
    ppu_ctrl1 = 8'h80;
    #1;
    check("nmi_ctrl_reraise", 32'(nmi), 32'd1);
    @(negedge clk);
    vblank_clr = 1'b1;
    @(negedge clk);
    vblank_clr = 1'b0;
    check("vblank_cleared", 32'(vblank), 32'd0);
    check("nmi_cleared", 32'(nmi), 32'd0);

    // Engine never acknowledges; eval_done held high as a level.
    ppu_ctrl2 = 8'h08;
    engine_on = 1'b0;
    eval_level = 1'b1;
    push_frame(3'd0, 3);
    pulse_frame(3'd0);
    @(negedge clk);
    check("eval_latency_bg_only", 32'(eval_start), 32'd1);
    count_until_load(n, 50);
    check("eval_to_load_gap", 32'(n), 32'd3);
    count_until_load(n, 50);
    check("timeout_tile_period", 32'(n), 32'd6);
    wait_q_empty(2000);
    do_reset();
    engine_on = 1'b1;
    eval_level = 1'b0;

    // fine_x = 3: 33 tiles per row; reset while row 50 is in flight.
    ppu_ctrl2 = 8'h10;
    busy_len = 1;
    push_frame(3'd3, 51);
    pulse_frame(3'd3);
    count_until_load(n, 100);
    check("fx3_first_col", 32'(curr_col), 32'h1FD);
    check("fx3_first_row", 32'(curr_row), 32'd0);
    wait_row_busy(9'd50, 20000);
    do_reset();
    ld_before = ld_cnt;
    repeat (30) @(negedge clk);
    check("no_load_after_reset", 32'(ld_cnt), 32'(ld_before));

    // Restart after reset: row 0 again from col_init.
    push_frame(3'd3, 1);
    pulse_frame(3'd3);
    count_until_load(n, 100);
    check("restart_first_col", 32'(curr_col), 32'h1FD);
    wait_q_empty(1000);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppu_frame_tile_sequencer.md
Name: ppu_frame_tile_sequencer

Overview:
- Frame-level scheduler for the PPU background/sprite tile load engine. Per frame it walks every visible scanline and every 8-pixel tile column (fine-X scroll applied) and triggers per-row sprite evaluation.
- Handshakes with the tile load engine through start/busy and drives its curr_row/curr_col.
- Owns the vblank flag and NMI request seen by the CPU-side register file.

Parameters:
- VISIBLE_ROWS, 240, scanlines rendered per frame.
- TILES_PER_ROW, 32, tile columns when fine_x==0 (one extra column when fine_x!=0).
- ACK_TIMEOUT, 4, max cycles to wait for load-engine busy to rise after start before treating the tile as done.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse, start of new frame (from VGA timing)
- fine_x  in  3  horizontal fine scroll, sampled at frame_start
- ppu_ctrl1  in  8  bit7 = NMI enable
- ppu_ctrl2  in  8  bit3 = background enable, bit4 = sprite enable
- vblank_clr  in  1  pulse, CPU read of status register
- load_start  out  1  one-cycle start pulse to tile load engine
- load_busy  in  1  tile load engine busy
- curr_row  out  9  screen row of current tile
- curr_col  out  9  screen column of current tile, two's complement (may be negative)
- eval_start  out  1  one-cycle pulse, begin sprite evaluation for curr_row
- eval_done  in  1  pulse or level, sprite evaluation complete
- vblank  out  1  vblank status flag
- nmi  out  1  NMI request level, equals vblank & ppu_ctrl1[7]
- frame_overrun  out  1  one-cycle pulse, frame_start arrived while rendering

Behaviour:
- Reset (async, active-low): state IDLE; load_start, eval_start, frame_overrun = 0; curr_row = 0; curr_col = 0; vblank = 0; ack counter = 0. Asserting reset mid-frame aborts immediately. No further load_start is issued until the next frame_start.
- render_en = ppu_ctrl2[3] | ppu_ctrl2[4], sampled at frame_start and held for the frame.
- col_init = 9'd0 - {6'b0, fine_x_latched}.
- ncols = TILES_PER_ROW + (fine_x_latched != 0).
- States:
  - IDLE: on frame_start, latch fine_x and render_en; vblank <= 0; curr_row <= 0; go ROW_EVAL.
  - ROW_EVAL: curr_col <= col_init; tile counter <= 0. If render_en: eval_start <= 1 for one cycle, go EVAL_WAIT. Else go NEXT_ROW.
  - EVAL_WAIT: when eval_done == 1, go TILE_START. A simultaneous eval_done in the eval_start cycle is ignored; only cycles after the pulse count.
  - TILE_START: only when load_busy == 0, load_start <= 1 for one cycle; clear ack counter; go TILE_ACK.
  - TILE_ACK: if load_busy == 1, go TILE_WAIT. Otherwise increment the ack counter; on reaching ACK_TIMEOUT go TILE_NEXT.
  - TILE_WAIT: when load_busy == 0, go TILE_NEXT.
  - TILE_NEXT: curr_col <= curr_col + 8 (9-bit wrap); tile counter + 1. If the counter reaches ncols, go NEXT_ROW; else go TILE_START.
  - NEXT_ROW: if curr_row == VISIBLE_ROWS-1, vblank <= 1 and go VBLANK. Else curr_row + 1 and go ROW_EVAL.
  - VBLANK: wait for frame_start, then act as in IDLE.
- curr_row and curr_col change only in TILE_NEXT, NEXT_ROW and ROW_EVAL. Both are stable from load_start until busy falls.
- Latency:
  - frame_start to first eval_start: 2 cycles.
  - load_start is never issued while load_busy == 1.
  - Minimum tile period is 3 cycles plus engine busy time.
- vblank:
  - Set on entry to VBLANK; cleared by vblank_clr or at frame_start.
  - If the set and vblank_clr occur in the same cycle, set wins.
- nmi is combinational: vblank & ppu_ctrl1[7]. Toggling ctrl1[7] during vblank re-raises nmi.
- frame_start outside IDLE/VBLANK: ignored for sequencing; frame_overrun pulses 1 cycle.
- Render disabled: no load_start or eval_start. Rows advance at 2 cycles/row (ROW_EVAL, NEXT_ROW), then VBLANK as normal.

Test Plan:
- fine_x=0, render on, engine model busy 10 cycles -> 32 load_start per row with curr_col 0,8,…,248 and 240 eval_start. vblank rises after row 239 tile 31.
- fine_x=3 -> 33 tiles/row; curr_col = 0x1FD, 0x005, 0x00D, …, 0x0FD; row 0 first load_start has curr_col=0x1FD.
- Engine never raises busy -> each tile advances after ACK_TIMEOUT=4 cycles; no hang; 32 tiles per row still counted.
- ppu_ctrl2=0x00 at frame_start -> zero load_start/eval_start; vblank high 480±2 cycles after frame_start. ctrl1[7]=1 -> nmi high; vblank_clr -> vblank and nmi low next cycle.
- frame_start pulsed at row 100 -> frame_overrun 1-cycle pulse; row sequence continues to 239 uninterrupted.
- rst low during TILE_WAIT at row 50 -> all outputs 0 immediately. After release, no load_start until frame_start, then restarts at row 0, col_init.
